pcie_tx_ctrl_fsm: RTL and testbench
===================================

Name: pcie_tx_ctrl_fsm

Overview:
Parametrised successor to the transmission-layer control FSM. It supervises NUM_FIFOS data FIFOs and loads the MF/VC/D threshold configuration during INIT. It reports IDLE, ACTIVE or ERROR, and adds per-FIFO error masking, recoverable errors with a latched error source, a saturating error-episode counter and threshold validation. It sits between the config/probe interface and the FIFO bank of the transmission layer.

Parameters:
NUM_FIFOS, 5, number of supervised FIFOs (width of empties/errors/mask vectors)
U_MFS, 4, width of MF threshold
U_VCS, 4, width of VC threshold
U_DS, 4, width of D threshold
ERR_CNT_W, 4, width of saturating error-episode counter

Ports:
clk  input  1  single clock; all state changes on rising edge
reset  input  1  synchronous, active-low reset
init  input  1  request (re)configuration
err_clear  input  1  request exit from ERROR
umbral_MFs  input  U_MFS  MF threshold to load
umbral_VCs  input  U_VCS  VC threshold to load
umbral_Ds  input  U_DS  D threshold to load
FIFO_empties  input  NUM_FIFOS  per-FIFO empty flags
FIFO_errors  input  NUM_FIFOS  per-FIFO error flags
error_mask  input  NUM_FIFOS  1 = ignore that FIFO's error
present_state  output  3  registered state code
next_state  output  3  combinational next-state code
init_out, idle_out, active_out, error_out  output  1 each  state flags
next_error  output  1  combinational: next_state==ERROR
umbral_MFs_out, umbral_VCs_out, umbral_Ds_out  output  U_MFS/U_VCS/U_DS  loaded thresholds
error_src  output  NUM_FIFOS  sticky unmasked error sources
error_count  output  ERR_CNT_W  number of ERROR entries, saturating

Behaviour:
- State codes: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4. Codes 5-7 are illegal and go to RESET on the next edge.
- reset=0 at a rising edge gives:
  - present_state=RESET.
  - All flags, thresholds, error_src and error_count = 0.
  - This applies in any state, including mid-ERROR; no other input matters.
- Flag outputs are decoded from present_state (Moore). Each flag is 1 only in its state; RESET drives all flags 0.
- eff_err = FIFO_errors & ~error_mask. It is evaluated every cycle.
- Transition priority in INIT, IDLE and ACTIVE: eff_err!=0 first, then init, then the normal rule.
- RESET: goes to INIT on the first edge with reset=1. Errors are ignored in RESET.
- INIT:
  - Threshold registers load the umbral_* inputs on every edge while present_state==INIT.
  - Goes to IDLE when init=0 and the currently loaded thresholds are all nonzero.
  - If any loaded threshold is 0, it stays in INIT.
- IDLE: goes to ACTIVE if any FIFO_empties bit is 0. Goes to INIT if init=1.
- ACTIVE: goes to IDLE when FIFO_empties is all ones. Goes to INIT if init=1.
- Any of INIT/IDLE/ACTIVE with eff_err!=0 goes to ERROR on the next edge (1-cycle latency).
- On the entering edge into ERROR:
  - error_src <= eff_err.
  - error_count increments by 1, saturating at 2^ERR_CNT_W-1.
- While in ERROR:
  - error_src |= eff_err on each edge.
  - error_count does not change.
- ERROR exit: goes to INIT when err_clear=1 and eff_err==0. On that edge, error_src clears to 0.
  - err_clear=1 with eff_err!=0: stays in ERROR.
  - error_count is retained until reset.
- Thresholds outside INIT hold their last loaded value. An error during INIT freezes the values loaded up to that edge.
- Masking: a masked error never causes ERROR and never sets error_src. Changing the mask while in ERROR affects only eff_err from that cycle on.
- next_state and next_error are pure combinational functions of present_state and the inputs.

Test Plan:
1. Reset and config:
   - Stimulus: reset=0 for 2 cycles, then 1; init=1 with MFs=3, VCs=5, Ds=7; init=0 after 3 cycles; all FIFOs empty.
   - Required: RESET→INIT→IDLE; umbral_*_out=3/5/7; idle_out=1; error_count=0.
2. Threshold validation:
   - Stimulus: in INIT, Ds=0 with init=0.
   - Required: stays INIT (init_out=1). Set Ds=2 → IDLE two edges later.
3. Activity:
   - Stimulus: from IDLE, FIFO_empties=5'b11011.
   - Required: next edge ACTIVE. Empties=5'b11111 → IDLE.
4. Error, masking and recovery:
   - Stimulus: error_mask=5'b00001; FIFO_errors=5'b00001.
   - Required: state unchanged.
   - Stimulus: FIFO_errors=5'b00100.
   - Required: next_error=1 combinationally; next edge ERROR with error_src=5'b00100, error_count=1.
   - Stimulus: err_clear=1 while the error is still present.
   - Required: stays ERROR.
   - Stimulus: errors cleared + err_clear=1.
   - Required: INIT with error_src=0, error_count=1.
5. Saturation: 16 error episodes with ERR_CNT_W=4 → error_count=15 and stays 15.
6. Reset mid-operation:
   - Stimulus: reset=0 in ERROR with errors still asserted.
   - Required: next edge RESET with all outputs 0. An illegal forced state 6 → RESET next edge.

Source files
------------

// File: rtl/pcie_tx_ctrl_fsm.sv
// Purpose: transmission-layer control FSM; loads thresholds, supervises a FIFO bank, tracks error episodes.
// Latency: next_state/next_error are combinational; state, flags, thresholds and error info update one edge later.
// Backpressure: none; FIFO status and config are sampled every cycle, and err_clear is held off while errors persist.
//
// Ports:
//   clk, reset (sync, active-low), init (reconfigure request), err_clear (leave ERROR)
//   umbral_MFs/VCs/Ds        thresholds loaded while in INIT
//   FIFO_empties/errors      per-FIFO status; error_mask bit = 1 ignores that FIFO's error
//   present_state/next_state registered / combinational state code
//   init_out..error_out      Moore state flags; next_error = (next_state == ERROR)
//   umbral_*_out             loaded thresholds
//   error_src                sticky unmasked error sources of the current episode
//   error_count              ERROR entries, saturating
module pcie_tx_ctrl_fsm #(
  parameter int NUM_FIFOS = 5,
  parameter int U_MFS     = 4,
  parameter int U_VCS     = 4,
  parameter int U_DS      = 4,
  parameter int ERR_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 err_clear,
  input  logic [U_MFS-1:0]     umbral_MFs,
  input  logic [U_VCS-1:0]     umbral_VCs,
  input  logic [U_DS-1:0]      umbral_Ds,
  input  logic [NUM_FIFOS-1:0] FIFO_empties,
  input  logic [NUM_FIFOS-1:0] FIFO_errors,
  input  logic [NUM_FIFOS-1:0] error_mask,
  output logic [2:0]           present_state,
  output logic [2:0]           next_state,
  output logic                 init_out,
  output logic                 idle_out,
  output logic                 active_out,
  output logic                 error_out,
  output logic                 next_error,
  output logic [U_MFS-1:0]     umbral_MFs_out,
  output logic [U_VCS-1:0]     umbral_VCs_out,
  output logic [U_DS-1:0]      umbral_Ds_out,
  output logic [NUM_FIFOS-1:0] error_src,
  output logic [ERR_CNT_W-1:0] error_count
);

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  logic [NUM_FIFOS-1:0] eff_err;
  logic                 any_err;
  logic                 thr_ok;
  logic                 all_empty;

  assign eff_err   = FIFO_errors & ~error_mask;
  assign any_err   = |eff_err;
  assign all_empty = &FIFO_empties;
  // Validation looks at the registered thresholds, so a new nonzero value
  // needs one INIT edge to be loaded before the exit to IDLE can happen.
  assign thr_ok    = (|umbral_MFs_out) && (|umbral_VCs_out) && (|umbral_Ds_out);

  // Priority in the operational states: error, then init, then normal rule.
  always_comb begin
    next_state = ST_RESET;
    if (reset) begin
      case (present_state)
        ST_RESET:  next_state = ST_INIT;
        ST_INIT: begin
          if (any_err)               next_state = ST_ERROR;
          else if (!init && thr_ok)  next_state = ST_IDLE;
          else                       next_state = ST_INIT;
        end
        ST_IDLE: begin
          if (any_err)               next_state = ST_ERROR;
          else if (init)             next_state = ST_INIT;
          else if (!all_empty)       next_state = ST_ACTIVE;
          else                       next_state = ST_IDLE;
        end
        ST_ACTIVE: begin
          if (any_err)               next_state = ST_ERROR;
          else if (init)             next_state = ST_INIT;
          else if (all_empty)        next_state = ST_IDLE;
          else                       next_state = ST_ACTIVE;
        end
        ST_ERROR: begin
          if (err_clear && !any_err) next_state = ST_INIT;
          else                       next_state = ST_ERROR;
        end
        default:                     next_state = ST_RESET;
      endcase
    end
  end

  assign next_error = (next_state == ST_ERROR);

  assign init_out   = (present_state == ST_INIT);
  assign idle_out   = (present_state == ST_IDLE);
  assign active_out = (present_state == ST_ACTIVE);
  assign error_out  = (present_state == ST_ERROR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      present_state  <= ST_RESET;
      umbral_MFs_out <= '0;
      umbral_VCs_out <= '0;
      umbral_Ds_out  <= '0;
      error_src      <= '0;
      error_count    <= '0;
    end else begin
      present_state <= next_state;

      // Loading every INIT edge means an error during INIT freezes whatever
      // was captured up to and including the edge that leaves INIT.
      if (present_state == ST_INIT) begin
        umbral_MFs_out <= umbral_MFs;
        umbral_VCs_out <= umbral_VCs;
        umbral_Ds_out  <= umbral_Ds;
      end

      if (present_state == ST_ERROR) begin
        if (next_state == ST_INIT) error_src <= '0;
        else                       error_src <= error_src | eff_err;
      end else if (next_state == ST_ERROR) begin
        error_src <= eff_err;
        if (error_count != CNT_MAX) error_count <= error_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pcie_tx_ctrl_fsm.sv
module tb_pcie_tx_ctrl_fsm;

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_IDLE   = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  logic       clk;
  logic       reset, init, err_clear;
  logic [3:0] umbral_MFs, umbral_VCs, umbral_Ds;
  logic [4:0] FIFO_empties, FIFO_errors, error_mask;
  logic [2:0] present_state, next_state;
  logic       init_out, idle_out, active_out, error_out, next_error;
  logic [3:0] umbral_MFs_out, umbral_VCs_out, umbral_Ds_out;
  logic [4:0] error_src;
  logic [3:0] error_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [4:0] src;
    logic [3:0] cnt;
    logic [11:0] thr;
  } exp_t;

  exp_t q[$];

  pcie_tx_ctrl_fsm dut (
    .clk(clk), .reset(reset), .init(init), .err_clear(err_clear),
    .umbral_MFs(umbral_MFs), .umbral_VCs(umbral_VCs), .umbral_Ds(umbral_Ds),
    .FIFO_empties(FIFO_empties), .FIFO_errors(FIFO_errors), .error_mask(error_mask),
    .present_state(present_state), .next_state(next_state),
    .init_out(init_out), .idle_out(idle_out), .active_out(active_out), .error_out(error_out),
    .next_error(next_error),
    .umbral_MFs_out(umbral_MFs_out), .umbral_VCs_out(umbral_VCs_out), .umbral_Ds_out(umbral_Ds_out),
    .error_src(error_src), .error_count(error_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] flags_of(input logic [2:0] st);
    case (st)
      S_INIT:   return 4'b1000;
      S_IDLE:   return 4'b0100;
      S_ACTIVE: return 4'b0010;
      S_ERROR:  return 4'b0001;
      default:  return 4'b0000;
    endcase
  endfunction

  task automatic push(input string tag, input logic [2:0] st, input logic [4:0] src,
                      input logic [3:0] cnt, input logic [3:0] mf, input logic [3:0] vc,
                      input logic [3:0] d);
    exp_t e;
    e.tag = tag; e.st = st; e.src = src; e.cnt = cnt; e.thr = {mf, vc, d};
    q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (q.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard: output observed with no expectation queued");
      return;
    end
    e = q.pop_front();
    tests++;
    assert (present_state === e.st) else begin
      fails++;
      $error("FAIL %s state: got %0d expected %0d", e.tag, present_state, e.st);
    end
    tests++;
    assert ({init_out, idle_out, active_out, error_out} === flags_of(e.st)) else begin
      fails++;
      $error("FAIL %s flags: got %b expected %b", e.tag,
             {init_out, idle_out, active_out, error_out}, flags_of(e.st));
    end
    tests++;
    assert ({error_src, error_count} === {e.src, e.cnt}) else begin
      fails++;
      $error("FAIL %s err: got src=%b cnt=%0d expected src=%b cnt=%0d", e.tag,
             error_src, error_count, e.src, e.cnt);
    end
    tests++;
    assert ({umbral_MFs_out, umbral_VCs_out, umbral_Ds_out} === e.thr) else begin
      fails++;
      $error("FAIL %s thr: got %h expected %h", e.tag,
             {umbral_MFs_out, umbral_VCs_out, umbral_Ds_out}, e.thr);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  initial begin
    reset = 1'b0; init = 1'b0; err_clear = 1'b0;
    umbral_MFs = 4'd0; umbral_VCs = 4'd0; umbral_Ds = 4'd0;
    FIFO_empties = 5'b11111; FIFO_errors = 5'b00000; error_mask = 5'b00000;

    // 1. reset and configuration
    push("rst_a", S_RESET, 5'b0, 4'd0, 4'd0, 4'd0, 4'd0); tick();
    push("rst_b", S_RESET, 5'b0, 4'd0, 4'd0, 4'd0, 4'd0); tick();
    reset = 1'b1; init = 1'b1;
    umbral_MFs = 4'd3; umbral_VCs = 4'd5; umbral_Ds = 4'd7;
    push("cfg_enter", S_INIT, 5'b0, 4'd0, 4'd0, 4'd0, 4'd0); tick();
    push("cfg_load",  S_INIT, 5'b0, 4'd0, 4'd3, 4'd5, 4'd7); tick();
    push("cfg_hold",  S_INIT, 5'b0, 4'd0, 4'd3, 4'd5, 4'd7); tick();
    init = 1'b0;
    push("cfg_idle",  S_IDLE, 5'b0, 4'd0, 4'd3, 4'd5, 4'd7); tick();

    // 2. threshold validation
    init = 1'b1; umbral_Ds = 4'd0;
    push("val_reinit", S_INIT, 5'b0, 4'd0, 4'd3, 4'd5, 4'd7); tick();
    push("val_loadz",  S_INIT, 5'b0, 4'd0, 4'd3, 4'd5, 4'd0); tick();
    init = 1'b0;
    push("val_stay1",  S_INIT, 5'b0, 4'd0, 4'd3, 4'd5, 4'd0); tick();
    push("val_stay2",  S_INIT, 5'b0, 4'd0, 4'd3, 4'd5, 4'd0); tick();
    umbral_Ds = 4'd2;
    push("val_load2",  S_INIT, 5'b0, 4'd0, 4'd3, 4'd5, 4'd2); tick();
    push("val_idle",   S_IDLE, 5'b0, 4'd0, 4'd3, 4'd5, 4'd2); tick();

    // 3. activity
    FIFO_empties = 5'b11011;
    #1 chk("act_next", {1'b0, next_state}, {1'b0, S_ACTIVE});
    push("act_go",   S_ACTIVE, 5'b0, 4'd0, 4'd3, 4'd5, 4'd2); tick();
    push("act_hold", S_ACTIVE, 5'b0, 4'd0, 4'd3, 4'd5, 4'd2); tick();
    FIFO_empties = 5'b11111;
    push("act_idle", S_IDLE,   5'b0, 4'd0, 4'd3, 4'd5, 4'd2); tick();

    // 4. error, masking, recovery
    error_mask = 5'b00001; FIFO_errors = 5'b00001;
    #1 chk("mask_nexterr", {3'b0, next_error}, 4'd0);
    push("mask_idle", S_IDLE, 5'b0, 4'd0, 4'd3, 4'd5, 4'd2); tick();
    FIFO_errors = 5'b00100;
    #1 chk("err_nexterr", {3'b0, next_error}, 4'd1);
    chk("err_nextst", {1'b0, next_state}, {1'b0, S_ERROR});
    push("err_enter", S_ERROR, 5'b00100, 4'd1, 4'd3, 4'd5, 4'd2); tick();
    err_clear = 1'b1; FIFO_errors = 5'b00111;
    push("err_stay", S_ERROR, 5'b00110, 4'd1, 4'd3, 4'd5, 4'd2); tick();
    FIFO_errors = 5'b00000;
    push("err_exit", S_INIT, 5'b00000, 4'd1, 4'd3, 4'd5, 4'd2); tick();
    err_clear = 1'b0;

    // 5. saturation of the episode counter
    for (int i = 0; i < 16; i++) begin
      logic [3:0] c;
      c = (i + 2 > 15) ? 4'd15 : 4'(i + 2);
      FIFO_errors = 5'b00100; err_clear = 1'b0;
      push("sat_err", S_ERROR, 5'b00100, c, 4'd3, 4'd5, 4'd2); tick();
      FIFO_errors = 5'b00000; err_clear = 1'b1;
      push("sat_clr", S_INIT, 5'b00000, c, 4'd3, 4'd5, 4'd2); tick();
    end
    err_clear = 1'b0;

    // 6. reset while in ERROR with errors asserted
    FIFO_errors = 5'b00100;
    push("mid_err", S_ERROR, 5'b00100, 4'd15, 4'd3, 4'd5, 4'd2); tick();
    reset = 1'b0;
    push("mid_rst", S_RESET, 5'b0, 4'd0, 4'd0, 4'd0, 4'd0); tick();
    push("mid_rst2", S_RESET, 5'b0, 4'd0, 4'd0, 4'd0, 4'd0); tick();

    // illegal state code falls back to RESET
    reset = 1'b1; FIFO_errors = 5'b00000;
    force dut.present_state = 3'd6;
    #1;
    chk("ill_next", {1'b0, next_state}, {1'b0, S_RESET});
    chk("ill_flags", {init_out, idle_out, active_out, error_out}, 4'b0000);
    chk("ill_nexterr", {3'b0, next_error}, 4'd0);
    release dut.present_state;

    tests++;
    assert (q.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_drain: got %0d left expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
